reg_write_arb: RTL and testbench
================================

Name: reg_write_arb

Overview:
- Arbitrates the register file's single write port (RdAddr/RdData) between three sources: pipeline writeback, the multiply/divide unit and the load-return path.
- Pipeline writeback has priority. The mult/div and load results are each parked in a one-entry holding register and drained round-robin into idle write slots.
- A starvation counter forces a pipeline stall so parked results cannot wait forever.
- Sits between the writeback stage and the register file. Address 0 is the idle/no-write code.

Parameters:
- MAX_WAIT, 4, cycles a parked entry may wait ungranted before Stall is raised.
- WAIT_W, 3, width of each wait counter; must hold MAX_WAIT.

Ports:
- Clock  in  1  system clock, rising edge
- nReset  in  1  asynchronous active-low reset
- WbValid  in  1  pipeline writeback request; no backpressure except Stall
- WbAddr  in  5  writeback destination register
- WbData  in  32  writeback data
- MdValid  in  1  mult/div result valid
- MdAddr  in  5  mult/div destination
- MdData  in  32  mult/div result
- MdReady  out  1  mult/div result accepted when MdValid and MdReady
- LdValid  in  1  load data valid
- LdAddr  in  5  load destination
- LdData  in  32  load data
- LdReady  out  1  load result accepted when LdValid and LdReady
- Stall  out  1  registered; pipeline must hold WbValid/WbAddr/WbData stable this cycle
- RdAddr  out  5  register file write address, registered; 0 = no write
- RdData  out  32  register file write data, registered

Behaviour:
- Reset (asynchronous, nReset low):
  - RdAddr=0, RdData=0, Stall=0.
  - Both holding registers empty and both wait counters 0, so MdReady=1 and LdReady=1.
  - Round-robin pointer set to Md.
  - A reset mid-operation discards any parked results.
- Handshake:
  - MdReady = !MdHeld | MdGrant; LdReady likewise. This gives one accept per cycle per source.
  - An accepted entry with address 0 is dropped and never held.
  - A captured entry becomes eligible for grant the cycle after capture.
- Grant, evaluated each cycle:
  - If Stall=0 and WbValid and WbAddr≠0: Wb wins.
  - Otherwise the eligible held entry wins. If both Md and Ld are held, the round-robin pointer selects, then flips to the other source.
  - If Stall=1, WbValid is ignored for the cycle.
- Output latency: the winner appears on RdAddr/RdData at the next rising edge (1 cycle). With no winner, RdAddr=0 and RdData holds its previous value.
- WAW ordering: held entries are older than any Wb. When a Wb grant targets the same address as a held entry, that held entry is cleared without writing and its counter is reset. Both Md and Ld may be cleared in one cycle.
- Wait counters:
  - Increment, saturating at MAX_WAIT, each cycle an entry is held and not granted.
  - Cleared on grant or on WAW clear.
- Stall_next = 1 when any held entry's counter equals MAX_WAIT and that entry is not granted this cycle. Stall is high for exactly one cycle per trigger and re-arms while starvation persists.
- Simultaneous Md and Ld accept into empty holds: both are captured in the same cycle; Md drains first from reset.

Optional Feature:
- Macro REG_ARB_BYPASS_EN. Extra ports: RsAddr/RtAddr in 5, RsIn/RtIn in 32 (raw register file read data), RsData/RtData out 32.
- With the macro: RsData = RdData when RsAddr==RdAddr and RdAddr≠0, otherwise RsIn (combinational; Rt identical). This forwards the write in flight during its commit cycle.
- Without the macro: RsData=RsIn and RtData=RtIn, with no compare logic.

Test Plan:
- Reset, then WbValid=1, WbAddr=5, WbData=0x1234 for 1 cycle -> next edge RdAddr=5, RdData=0x1234; the following cycle RdAddr=0.
- MdValid with addr 7, data 0xAA and LdValid with addr 9, data 0xBB in the same cycle, Wb idle -> both Ready=1. Then RdAddr=7/0xAA, then 9/0xBB on consecutive cycles. Ready stays 1 throughout.
- Parked Md with addr 3; WbValid with WbAddr≠3 asserted continuously -> Stall=1 exactly 5 cycles after capture. That cycle Wb is ignored and RdAddr=3 on the next edge.
- Parked Ld with addr 4, then Wb writes addr 4 value 0x55 -> RdAddr=4/0x55 once. The Ld entry is discarded and LdReady returns to 1.
- MdValid with MdAddr=0 -> accepted, no write, MdReady stays 1. Assert nReset=0 while Ld is parked -> RdAddr=0, Stall=0, LdReady=1 immediately.
- REG_ARB_BYPASS_EN: Wb write r6=0x99 with RsAddr=6, RsIn=0 during the commit cycle -> RsData=0x99. Without the macro -> RsData=0.

Source files
------------

// File: rtl/reg_write_arb.sv
// Register-file write-port arbiter: pipeline writeback first, then parked mult/div and load
// results drained round-robin, with a starvation stall. Optional operand forwarding: REG_ARB_BYPASS_EN.
module reg_write_arb #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 3
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        WbValid,
  input  logic [4:0]  WbAddr,
  input  logic [31:0] WbData,
  input  logic        MdValid,
  input  logic [4:0]  MdAddr,
  input  logic [31:0] MdData,
  output logic        MdReady,
  input  logic        LdValid,
  input  logic [4:0]  LdAddr,
  input  logic [31:0] LdData,
  output logic        LdReady,
  output logic        Stall,
  output logic [4:0]  RdAddr,
  output logic [31:0] RdData,
  input  logic [4:0]  RsAddr,
  input  logic [4:0]  RtAddr,
  input  logic [31:0] RsIn,
  input  logic [31:0] RtIn,
  output logic [31:0] RsData,
  output logic [31:0] RtData
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {SRC_MD = 1'b0, SRC_LD = 1'b1} rrSrc_t;

  rrSrc_t              rrPtr;
  logic                mdHeld, ldHeld;
  logic [ADDR_W-1:0]   mdAddrQ, ldAddrQ;
  logic [DATA_W-1:0]   mdDataQ, ldDataQ;
  logic [WAIT_W-1:0]   mdCnt, ldCnt;

  logic wbGrant, mdGrant, ldGrant;
  logic mdWaw, ldWaw;
  logic mdCapture, ldCapture;
  logic stallNext;

  // Grant selection, write-after-write squash and starvation detect
  always_comb begin
    wbGrant   = 1'b0;
    mdGrant   = 1'b0;
    ldGrant   = 1'b0;
    mdWaw     = 1'b0;
    ldWaw     = 1'b0;
    mdCapture = 1'b0;
    ldCapture = 1'b0;
    stallNext = 1'b0;

    wbGrant = !Stall && WbValid && (WbAddr != '0);
    if (!wbGrant) begin
      mdGrant = mdHeld && (!ldHeld || (rrPtr == SRC_MD));
      ldGrant = ldHeld && (!mdHeld || (rrPtr == SRC_LD));
    end
    mdWaw = wbGrant && mdHeld && (mdAddrQ == WbAddr);
    ldWaw = wbGrant && ldHeld && (ldAddrQ == WbAddr);

    mdCapture = MdValid && MdReady && (MdAddr != '0);
    ldCapture = LdValid && LdReady && (LdAddr != '0);

    stallNext = (mdHeld && (mdCnt == WAIT_MAX) && !mdGrant && !mdWaw) ||
                (ldHeld && (ldCnt == WAIT_MAX) && !ldGrant && !ldWaw);
  end

  assign MdReady = !mdHeld || mdGrant;
  assign LdReady = !ldHeld || ldGrant;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rrPtr   <= SRC_MD;
      mdHeld  <= 1'b0;
      ldHeld  <= 1'b0;
      mdAddrQ <= '0;
      ldAddrQ <= '0;
      mdDataQ <= '0;
      ldDataQ <= '0;
      mdCnt   <= '0;
      ldCnt   <= '0;
      Stall   <= 1'b0;
      RdAddr  <= '0;
      RdData  <= '0;
    end else begin
      Stall <= stallNext;

      // Write-port output register; data holds when idle
      if (wbGrant) begin
        RdAddr <= WbAddr;
        RdData <= WbData;
      end else if (mdGrant) begin
        RdAddr <= mdAddrQ;
        RdData <= mdDataQ;
      end else if (ldGrant) begin
        RdAddr <= ldAddrQ;
        RdData <= ldDataQ;
      end else begin
        RdAddr <= '0;
      end

      if (!wbGrant && mdHeld && ldHeld) begin
        rrPtr <= (rrPtr == SRC_MD) ? SRC_LD : SRC_MD;
      end

      if (mdCapture) begin
        mdHeld  <= 1'b1;
        mdAddrQ <= MdAddr;
        mdDataQ <= MdData;
      end else if (mdGrant || mdWaw) begin
        mdHeld <= 1'b0;
      end

      if (ldCapture) begin
        ldHeld  <= 1'b1;
        ldAddrQ <= LdAddr;
        ldDataQ <= LdData;
      end else if (ldGrant || ldWaw) begin
        ldHeld <= 1'b0;
      end

      // Wait counters only advance while parked and passed over
      if (!mdHeld || mdGrant || mdWaw) begin
        mdCnt <= '0;
      end else if (mdCnt != WAIT_MAX) begin
        mdCnt <= mdCnt + WAIT_W'(1);
      end

      if (!ldHeld || ldGrant || ldWaw) begin
        ldCnt <= '0;
      end else if (ldCnt != WAIT_MAX) begin
        ldCnt <= ldCnt + WAIT_W'(1);
      end
    end
  end

`ifdef REG_ARB_BYPASS_EN
  // Forward the write being committed this cycle to same-cycle readers
  assign RsData = ((RsAddr == RdAddr) && (RdAddr != '0)) ? RdData : RsIn;
  assign RtData = ((RtAddr == RdAddr) && (RdAddr != '0)) ? RdData : RtIn;
`else
  logic unusedAddr;
  assign unusedAddr = ^{RsAddr, RtAddr};
  assign RsData = RsIn;
  assign RtData = RtIn;
`endif

endmodule

// File: tb/tb_reg_write_arb.sv
// Directed self-checking bench for reg_write_arb; inputs driven and outputs sampled at negedge.
module tb_reg_write_arb;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        WbValid, MdValid, LdValid;
  logic [4:0]  WbAddr, MdAddr, LdAddr, RsAddr, RtAddr, RdAddr;
  logic [31:0] WbData, MdData, LdData, RsIn, RtIn, RsData, RtData, RdData;
  logic        MdReady, LdReady, Stall;

  int nChecks = 0;
  int nBad    = 0;

  always #5 Clock = ~Clock;

  reg_write_arb #(.MAX_WAIT(4), .WAIT_W(3)) dut (
    .Clock(Clock), .nReset(nReset),
    .WbValid(WbValid), .WbAddr(WbAddr), .WbData(WbData),
    .MdValid(MdValid), .MdAddr(MdAddr), .MdData(MdData), .MdReady(MdReady),
    .LdValid(LdValid), .LdAddr(LdAddr), .LdData(LdData), .LdReady(LdReady),
    .Stall(Stall), .RdAddr(RdAddr), .RdData(RdData),
    .RsAddr(RsAddr), .RtAddr(RtAddr), .RsIn(RsIn), .RtIn(RtIn),
    .RsData(RsData), .RtData(RtData)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    nReset  = 1'b0;
    WbValid = 0; WbAddr = 0; WbData = 0;
    MdValid = 0; MdAddr = 0; MdData = 0;
    LdValid = 0; LdAddr = 0; LdData = 0;
    RsAddr  = 0; RtAddr = 0; RsIn = 0; RtIn = 0;
    #3;
    check("rst_rdaddr", 32'(RdAddr), 32'd0);
    check("rst_rddata", RdData, 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_mdready", 32'(MdReady), 32'd1);
    check("rst_ldready", 32'(LdReady), 32'd1);
    @(negedge Clock);
    nReset = 1'b1;

    // Single writeback
    WbValid = 1; WbAddr = 5'd5; WbData = 32'h1234;
    step();
    WbValid = 0;
    check("wb_addr", 32'(RdAddr), 32'd5);
    check("wb_data", RdData, 32'h1234);
    step();
    check("wb_idle_addr", 32'(RdAddr), 32'd0);
    check("wb_idle_data_hold", RdData, 32'h1234);

    // Simultaneous Md/Ld capture, Md drains first
    MdValid = 1; MdAddr = 5'd7; MdData = 32'hAA;
    LdValid = 1; LdAddr = 5'd9; LdData = 32'hBB;
    #1;
    check("dual_mdready", 32'(MdReady), 32'd1);
    check("dual_ldready", 32'(LdReady), 32'd1);
    step();
    MdValid = 0; LdValid = 0;
    #1;
    check("dual_mdready_held", 32'(MdReady), 32'd1);
    step();
    check("dual_first_addr", 32'(RdAddr), 32'd7);
    check("dual_first_data", RdData, 32'hAA);
    check("dual_ldready_grant", 32'(LdReady), 32'd1);
    step();
    check("dual_second_addr", 32'(RdAddr), 32'd9);
    check("dual_second_data", RdData, 32'hBB);
    step();
    check("dual_idle", 32'(RdAddr), 32'd0);

    // Starvation: continuous Wb to r10 while Md r3 is parked
    WbValid = 1; WbAddr = 5'd10; WbData = 32'h100;
    MdValid = 1; MdAddr = 5'd3; MdData = 32'h33;
    step();
    MdValid = 0;
    check("starve_wb0", 32'(RdAddr), 32'd10);
    check("starve_stall0", 32'(Stall), 32'd0);
    #1;
    check("starve_mdready_held", 32'(MdReady), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("starve_stall_c%0d", i), 32'(Stall), 32'd0);
      check($sformatf("starve_wb_c%0d", i), 32'(RdAddr), 32'd10);
    end
    step();
    check("starve_stall_on", 32'(Stall), 32'd1);
    step();
    check("starve_md_addr", 32'(RdAddr), 32'd3);
    check("starve_md_data", RdData, 32'h33);
    check("starve_stall_off", 32'(Stall), 32'd0);
    step();
    check("starve_wb_resume", 32'(RdAddr), 32'd10);
    WbValid = 0;
    step();
    check("starve_idle", 32'(RdAddr), 32'd0);

    // WAW: Wb to the parked Ld address squashes the Ld entry
    LdValid = 1; LdAddr = 5'd4; LdData = 32'h44;
    step();
    LdValid = 0;
    WbValid = 1; WbAddr = 5'd4; WbData = 32'h55;
    #1;
    check("waw_ldready_held", 32'(LdReady), 32'd0);
    step();
    WbValid = 0;
    check("waw_addr", 32'(RdAddr), 32'd4);
    check("waw_data", RdData, 32'h55);
    #1;
    check("waw_ldready_back", 32'(LdReady), 32'd1);
    step();
    check("waw_no_second", 32'(RdAddr), 32'd0);
    check("waw_data_hold", RdData, 32'h55);

    // Address-0 Md result is accepted and dropped
    MdValid = 1; MdAddr = 5'd0; MdData = 32'hDEAD;
    #1;
    check("zero_mdready", 32'(MdReady), 32'd1);
    step();
    MdValid = 0;
    #1;
    check("zero_mdready_after", 32'(MdReady), 32'd1);
    step();
    check("zero_nowrite", 32'(RdAddr), 32'd0);

    // Mid-operation reset discards a parked Ld
    LdValid = 1; LdAddr = 5'd12; LdData = 32'hCC;
    step();
    LdValid = 0;
    WbValid = 1; WbAddr = 5'd13; WbData = 32'h13;
    step();
    #1;
    check("rst2_ldready_held", 32'(LdReady), 32'd0);
    check("rst2_wb_addr", 32'(RdAddr), 32'd13);
    nReset = 1'b0;
    #1;
    check("rst2_rdaddr", 32'(RdAddr), 32'd0);
    check("rst2_rddata", RdData, 32'd0);
    check("rst2_stall", 32'(Stall), 32'd0);
    check("rst2_ldready", 32'(LdReady), 32'd1);
    WbValid = 0;
    @(negedge Clock);
    nReset = 1'b1;
    step();
    check("rst2_discarded", 32'(RdAddr), 32'd0);

    // Forwarding of the write in its commit cycle
    WbValid = 1; WbAddr = 5'd6; WbData = 32'h99;
    RsAddr = 5'd6; RsIn = 32'h0; RtAddr = 5'd6; RtIn = 32'h77;
    step();
    WbValid = 0;
    check("byp_rdaddr", 32'(RdAddr), 32'd6);
`ifdef REG_ARB_BYPASS_EN
    check("byp_rs", RsData, 32'h99);
    check("byp_rt", RtData, 32'h99);
`else
    check("byp_rs", RsData, 32'h0);
    check("byp_rt", RtData, 32'h77);
`endif
    step();
`ifdef REG_ARB_BYPASS_EN
    check("byp_rs_after", RsData, 32'h0);
`else
    check("byp_rs_after", RsData, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule
